// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between pipeline and the multiply/divide unit
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] wdat;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rdat1, rdat2, hi_wen, lo_wen, wdat,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rdat1, rdat2, hi_wen, lo_wen, wdat,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers
// Works on operand magnitudes for 32 steps, then applies sign correction in FIX.
module muldiv_unit (
  input  logic         CLK,
  input  logic         RST,
  muldiv_unit_if.slave bus
);
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  word_t       a_raw;
  word_t       opnd;
  word_t       acc_hi;
  word_t       acc_lo;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  word_t       hi_q;
  word_t       lo_q;
  logic        done_q;

  logic        accept;
  logic        a_neg;
  logic        b_neg;
  word_t       mag_a;
  word_t       mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] product;
  word_t       res_hi;
  word_t       res_lo;

  assign accept = (state == IDLE) && bus.start;
  assign a_neg  = bus.op[0] & bus.rdat1[31];
  assign b_neg  = bus.op[0] & bus.rdat2[31];
  assign mag_a  = a_neg ? (~bus.rdat1 + 32'd1) : bus.rdat1;
  assign mag_b  = b_neg ? (~bus.rdat2 + 32'd1) : bus.rdat2;

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : 32'd0)};
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_trial = div_shift - {1'b0, opnd};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    product = neg_res ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    res_hi  = product[63:32];
    res_lo  = product[31:0];
    if (op_q[1]) begin
      // Divide by zero reports all-ones quotient and the untouched dividend.
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
        res_lo = neg_res ? (~acc_lo + 32'd1) : acc_lo;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= 5'd0;
      op_q     <= 2'd0;
      a_raw    <= 32'd0;
      opnd     <= 32'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= 5'd0;
            op_q     <= bus.op;
            a_raw    <= bus.rdat1;
            opnd     <= bus.op[1] ? mag_b : mag_a;
            acc_hi   <= 32'd0;
            acc_lo   <= bus.op[1] ? mag_a : mag_b;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (bus.rdat2 == 32'd0);
          end else begin
            if (bus.hi_wen) hi_q <= bus.wdat;
            if (bus.lo_wen) lo_q <= bus.wdat;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (op_q[1]) begin
            acc_hi <= div_trial[32] ? div_shift[31:0] : div_trial[31:0];
            acc_lo <= {acc_lo[30:0], ~div_trial[32]};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_fail;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the request and returns 1ns after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.rdat1 = a;
    bus.rdat2 = b;
    bus.start = 1'b1;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic finish_op(input string tag, input bit disturb,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_n = 0;
    int done_n = 0;
    int lat    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        lat = i;
      end
      if (disturb && i == 5) begin
        bus.rdat1  = 32'd999;
        bus.rdat2  = 32'd3;
        bus.op     = 2'b00;
        bus.start  = 1'b1;
        bus.hi_wen = 1'b1;
        bus.lo_wen = 1'b1;
        bus.wdat   = 32'hDEAD_BEEF;
      end
      if (disturb && i == 6) begin
        bus.start  = 1'b0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
      end
    end
    check({tag, " busy_cycles"}, busy_n, 32'd33);
    check({tag, " done_pulses"}, done_n, 32'd1);
    check({tag, " latency"}, lat, 32'd34);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int done_n;
    n_cmp      = 0;
    n_fail     = 0;
    RST        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rdat1  = 32'd0;
    bus.rdat2  = 32'd0;
    bus.hi_wen = 1'b0;
    bus.lo_wen = 1'b0;
    bus.wdat   = 32'd0;
    repeat (3) @(negedge CLK);
    check("reset busy", bus.busy, 32'd0);
    check("reset done", bus.done, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);

    // Start on the very first edge with reset released.
    RST = 1'b0;
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

    start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    finish_op("mult_neg", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    start_op(2'b10, 32'd7, 32'd0);
    finish_op("divu_by0", 1'b0, 32'd7, 32'hFFFF_FFFF);

    start_op(2'b11, 32'hFFFF_FFFB, 32'd0);
    finish_op("div_neg_by0", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 1'b0, 32'd0, 32'h8000_0000);

    start_op(2'b10, 32'd100, 32'd7);
    finish_op("divu_disturb", 1'b1, 32'd2, 32'd14);

    // Reset in the middle of a multiply.
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort busy", bus.busy, 32'd0);
    check("abort done", bus.done, 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    RST = 1'b0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.done) done_n++;
    end
    check("abort no_done", done_n, 32'd0);
    start_op(2'b00, 32'd3, 32'd4);
    finish_op("multu_3x4", 1'b0, 32'd0, 32'd12);

    // Direct HI/LO writes while idle.
    bus.hi_wen = 1'b1;
    bus.wdat   = 32'h5555_AAAA;
    @(negedge CLK);
    bus.hi_wen = 1'b0;
    check("mthi hi", bus.hi, 32'h5555_AAAA);
    check("mthi lo", bus.lo, 32'd12);
    bus.lo_wen = 1'b1;
    bus.wdat   = 32'h0000_1234;
    @(negedge CLK);
    bus.lo_wen = 1'b0;
    check("mtlo lo", bus.lo, 32'h0000_1234);
    check("mtlo hi", bus.hi, 32'h5555_AAAA);

    // A write strobe alongside an accepted start is dropped.
    bus.hi_wen = 1'b1;
    bus.wdat   = 32'h0BAD_0BAD;
    start_op(2'b00, 32'd3, 32'd4);
    bus.hi_wen = 1'b0;
    check("start_wen busy", bus.busy, 32'd1);
    check("start_wen hi", bus.hi, 32'h5555_AAAA);
    check("start_wen lo", bus.lo, 32'h0000_1234);
    finish_op("start_wen", 1'b0, 32'd0, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits (word_t).
REQ-002 SHALL have port CLK, in, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST, in, 1, synchronous active-high reset.
REQ-004 SHALL have port start, in, 1, request a new operation.
REQ-005 SHALL have port op, in, 2, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port rdat1, in, 32, rs operand (multiplicand/dividend) from register file read port 1.
REQ-007 SHALL have port rdat2, in, 32, rt operand (multiplier/divisor) from register file read port 2.
REQ-008 SHALL have port hi_wen, in, 1, MTHI strobe.
REQ-009 SHALL have port lo_wen, in, 1, MTLO strobe.
REQ-010 SHALL have port wdat, in, 32, data for MTHI/MTLO.
REQ-011 SHALL have port busy, out, 1, operation in progress (pipeline stall request).
REQ-012 SHALL have port done, out, 1, one-cycle pulse: result valid in hi/lo.
REQ-013 SHALL have port hi, out, 32, HI register, driven directly from a flop.
REQ-014 SHALL have port lo, out, 32, LO register, driven directly from a flop.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-016 In IDLE, start=1 at edge E0 SHALL latch op, rdat1, rdat2, enter RUN, clear 5-bit iteration counter to 0.
REQ-017 Operand or op changes after E0 SHALL have no effect on the result.
REQ-018 RUN SHALL perform exactly one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle on operand magnitudes, 32 steps, edges E1..E32; counter wraps 31->0 at E32, entering FIX.
REQ-019 FIX at E33 SHALL apply sign correction, write hi/lo, return to IDLE, and set done=1 for exactly the cycle after E33; done SHALL be 0 otherwise.
REQ-020 busy SHALL be 1 for exactly 33 cycles (after E0 through E33); latency from start to done = 34 cycles, independent of operand values and op.
REQ-021 MULTU/MULT SHALL produce the 64-bit product: hi = bits 63:32, lo = bits 31:0; MULT treats operands as two's complement.
REQ-022 DIVU SHALL give lo = quotient, hi = remainder, unsigned.
REQ-023 DIV SHALL truncate toward zero: quotient negative iff operand signs differ; remainder takes the sign of rdat1.
REQ-024 Divisor 0 (DIV or DIVU) SHALL give lo = 32'hFFFFFFFF, hi = latched rdat1, full 34-cycle latency, no error flag.
REQ-025 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo = 32'h80000000, hi = 0.
REQ-026 start while busy SHALL be ignored (no restart, no queuing).
REQ-027 In IDLE without start, hi_wen SHALL load hi <= wdat, lo_wen SHALL load lo <= wdat; both may assert in one cycle.
REQ-028 hi_wen/lo_wen while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-029 hi/lo SHALL hold their value during RUN; they change only at FIX or on REQ-027 writes.

Reset
REQ-030 RST=1 at any edge SHALL force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, overriding start and hi_wen/lo_wen, including aborting an operation mid-RUN or in FIX.
REQ-031 The first edge with RST=0 SHALL accept a start normally.

Verification
REQ-032 MULTU with rdat1=rdat2=32'hFFFFFFFF -> done in the cycle after E33, hi=32'hFFFFFFFE, lo=32'h00000001; busy high exactly 33 cycles.
REQ-033 MULT with rdat1=32'hFFFFFFFD, rdat2=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-034 DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 7/0 -> lo=32'hFFFFFFFF, hi=7; DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-035 Test DIVU 100/7; change rdat1/rdat2, pulse start, and pulse hi_wen during RUN -> lo=14, hi=2, single done pulse, hi not overwritten by wdat.
REQ-036 Assert RST at iteration 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows; a fresh MULTU 3*4 then yields lo=12, hi=0.
REQ-037 In IDLE, lo_wen=1 with wdat=32'h00001234 -> lo=32'h00001234 next cycle, hi unchanged; hi_wen and start together in IDLE -> operation starts, hi not written.
